// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small synchronous FIFO.
//
// Words arrive on a valid/ready stream and are queued in the FIFO. The
// framing state machine drains the queue and sends each word LSB first as
// start bit, DATA_BITS data bits, an optional parity bit and 1 or 2 stop
// bits. While words remain queued, the frames are sent back to back.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous reset, active-low
//   s_data      word to transmit
//   s_valid     producer has a word on s_data
//   s_ready     FIFO can accept a word (not full)
//   cfg_parity  00 none, 01 even, 10 odd, 11 none (latched per frame)
//   cfg_stop2   0 = one stop bit, 1 = two stop bits (latched per frame)
//   tx          serial line, idle high, registered
//   busy        frame in progress or FIFO non-empty, registered
//   fifo_level  number of words currently in the FIFO
module uart_tx_fifo #(
  parameter int CLK_FREQ  = 12000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_BITS-1:0]     s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [1:0]               cfg_parity,
  input  logic                     cfg_stop2,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int BW  = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  function automatic logic frame_parity(input logic [DATA_BITS-1:0] d,
                                        input logic odd);
    return (^d) ^ odd;
  endfunction

  // FIFO storage and control
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [LW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        level, level_d;
  logic                 ready_q;
  logic                 nempty_q;
  logic                 busy_q, busy_d;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  // Framing state
  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bitn_q;
  logic [DATA_BITS-1:0] sh_q;
  logic                 par_en_q, par_q, stop2_q, stop_n_q;
  logic                 tx_q;
  logic                 bit_tick, last_stop;

  assign level     = wr_ptr_q - rd_ptr_q;
  assign head      = mem[rd_ptr_q[AW-1:0]];
  assign push      = s_valid && ready_q;
  assign bit_tick  = (cnt_q == CW'(DIV - 1));
  // Final tick of the stop period: after the second stop bit when two are used.
  assign last_stop = (state_q == STOP) && bit_tick && (!stop2_q || stop_n_q);
  // nempty_q lags the level by one cycle, so a word written into an empty
  // FIFO is only seen by the framer on the following cycle.
  assign pop       = nempty_q && ((state_q == IDLE) || last_stop);

  always_comb begin
    level_d = level;
    if (push) level_d = level_d + LW'(1);
    if (pop)  level_d = level_d - LW'(1);
    // Next-state view of busy so the registered output matches the
    // state/level it describes in the same cycle.
    busy_d = pop || (level_d != '0) || ((state_q != IDLE) && !last_stop);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
      nempty_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + LW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + LW'(1);
      ready_q  <= (level_d != LW'(DEPTH));
      nempty_q <= (level != '0);
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitn_q   <= '0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      stop_n_q <= 1'b0;
      tx_q     <= 1'b1;
    end else if (pop) begin
      // Load a new frame; configuration is frozen for its duration.
      sh_q     <= head;
      par_en_q <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
      par_q    <= frame_parity(head, cfg_parity == 2'b10);
      stop2_q  <= cfg_stop2;
      stop_n_q <= 1'b0;
      cnt_q    <= '0;
      state_q  <= START;
      tx_q     <= 1'b0;
    end else begin
      cnt_q <= bit_tick ? '0 : cnt_q + CW'(1);
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          tx_q  <= 1'b1;
        end
        START: begin
          if (bit_tick) begin
            state_q <= DATA;
            bitn_q  <= '0;
            tx_q    <= sh_q[0];
          end
        end
        DATA: begin
          if (bit_tick) begin
            sh_q <= sh_q >> 1;
            if (bitn_q == BW'(DATA_BITS - 1)) begin
              if (par_en_q) begin
                state_q <= PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bitn_q <= bitn_q + BW'(1);
              tx_q   <= sh_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (stop2_q && !stop_n_q) begin
              stop_n_q <= 1'b1;
            end else begin
              // Queue empty at the end of the frame (otherwise pop wins).
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign s_ready    = ready_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_level = level;

endmodule
